// File: rtl/display_arbiter_pkg.sv
// Shared definitions for the display arbiter: FSM encodings, default idle word,
// and the hold counter sizing rule.
package display_arbiter_pkg;

    localparam logic [0:0]  ST_IDLE        = 1'b0;
    localparam logic [0:0]  ST_OWN         = 1'b1;
    localparam logic [15:0] DEF_IDLE_VALUE = 16'h0000;

    // A zero-tick hold still needs a 1-bit counter so the vector stays legal.
    function automatic int hold_cnt_width(input int hold_ticks);
        return (hold_ticks > 0) ? $clog2(hold_ticks + 1) : 1;
    endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Requester/display bus between the request sources and the display arbiter.
interface display_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        grant;
    logic [DATA_W-1:0]       disp_value;
    logic                    disp_valid;

    modport master (output req, req_data, input grant, disp_value, disp_valid);
    modport slave  (input req, req_data, output grant, disp_value, disp_valid);
endinterface

// File: rtl/display_arbiter_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks;
// reusable by any ms-based display timer.
module tick_prescaler #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner selection for the shared 7-segment display with a minimum
// on-screen time per owner; disp_value feeds the display multiplexer.
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int                N_REQ      = 4,
    parameter int                DATA_W     = 16,
    parameter int                TICK_DIV   = 50000,
    parameter int                HOLD_TICKS = 500,
    parameter logic [DATA_W-1:0] IDLE_VALUE = DATA_W'(DEF_IDLE_VALUE)
) (
    input logic              clk,
    input logic              rst_n,
    display_arbiter_if.slave bus
);
    localparam int              IDX_W    = $clog2(N_REQ);
    localparam int              HC_W     = hold_cnt_width(HOLD_TICKS);
    localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(HOLD_TICKS);

    logic [0:0]        state;
    logic [IDX_W-1:0]  owner_idx;
    logic [IDX_W-1:0]  rr_ptr;
    logic [N_REQ-1:0]  grant;
    logic [DATA_W-1:0] disp_value;
    logic [HC_W-1:0]   hold_cnt;

    logic              tick;
    logic              hold_done;
    logic              owner_req;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [DATA_W-1:0] owner_data;
    logic [DATA_W-1:0] pick_data;

    // First candidate at ptr, ptr+1, ... wrapping; lowest offset wins.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] cand,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] j;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = IDX_W'((int'(ptr) + k) % N_REQ);
            if (cand[j]) res = {1'b1, j};
        end
        return res;
    endfunction

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // The current owner is masked out so a hold expiry always rotates.
    assign {pick_found, pick_idx} = rr_pick(bus.req & ~grant, rr_ptr);

    assign owner_req  = |(bus.req & grant);
    assign owner_data = bus.req_data[owner_idx*DATA_W +: DATA_W];
    assign pick_data  = bus.req_data[pick_idx*DATA_W +: DATA_W];
    assign hold_done  = (HOLD_TICKS == 0) || (hold_cnt == HOLD_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner_idx  <= '0;
            rr_ptr     <= '0;
            grant      <= '0;
            disp_value <= IDLE_VALUE;
            hold_cnt   <= '0;
        end else if (pick_found && (state == ST_IDLE || hold_done)) begin
            state      <= ST_OWN;
            owner_idx  <= pick_idx;
            rr_ptr     <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            grant      <= N_REQ'(1) << pick_idx;
            disp_value <= pick_data;
            hold_cnt   <= '0;
        end else if (state == ST_OWN) begin
            if (hold_done && !owner_req) begin
                state      <= ST_IDLE;
                grant      <= '0;
                disp_value <= IDLE_VALUE;
            end else begin
                // A released owner keeps its last value frozen until the hold expires.
                if (owner_req)             disp_value <= owner_data;
                if (tick && !hold_done)    hold_cnt   <= hold_cnt + 1'b1;
            end
        end
    end

    assign bus.grant      = grant;
    assign bus.disp_value = disp_value;
    assign bus.disp_valid = |grant;
endmodule

// File: tb/tb_display_arbiter.sv
// Randomized scoreboard bench for display_arbiter with a cycle-level reference model.
module tb_display_arbiter;
    localparam int N        = 4;
    localparam int W        = 16;
    localparam int TICK_DIV = 4;
    localparam int HOLD     = 3;

    typedef struct packed {
        logic [N-1:0] grant;
        logic [W-1:0] value;
        logic         valid;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // reference model state
    int           m_owner;
    int           m_hold;
    int           m_ptr;
    int           m_pcnt;
    logic [W-1:0] m_val;

    display_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

    display_arbiter #(
        .N_REQ(N), .DATA_W(W), .TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD), .IDLE_VALUE(16'h0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_out();
        exp_t e;
        e.grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
        e.value = m_val;
        e.valid = (m_owner >= 0);
        return e;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_ptr   = 0;
        m_pcnt  = 0;
        m_val   = 16'h0000;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N*W-1:0] d);
        int  p;
        bit  tick;
        bit  done;
        bit  own_req;
        p       = -1;
        tick    = (m_pcnt == TICK_DIV - 1);
        done    = (m_hold >= HOLD);
        own_req = (m_owner >= 0) ? r[m_owner] : 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (p < 0 && r[j] && j != m_owner) p = j;
        end
        if (p >= 0 && (m_owner < 0 || done)) begin
            m_owner = p;
            m_val   = d[p*W +: W];
            m_hold  = 0;
            m_ptr   = (p + 1) % N;
        end else if (m_owner >= 0) begin
            if (done && !own_req) begin
                m_owner = -1;
                m_val   = 16'h0000;
            end else begin
                if (own_req) m_val = d[m_owner*W +: W];
                if (tick && !done) m_hold++;
            end
        end
        m_pcnt = (m_pcnt + 1) % TICK_DIV;
    endtask

    task automatic check(input string name, input exp_t e);
        total++;
        if (bus.grant !== e.grant || bus.disp_value !== e.value || bus.disp_valid !== e.valid) begin
            bad++;
            $display("FAIL %s @%0t: got grant=%b value=%h valid=%b, want grant=%b value=%h valid=%b",
                     name, $time, bus.grant, bus.disp_value, bus.disp_valid,
                     e.grant, e.value, e.valid);
        end
    endtask

    function automatic logic [N*W-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [N*W-1:0] with_lane(input logic [N*W-1:0] d, input int i,
                                                 input logic [W-1:0] v);
        logic [N*W-1:0] r;
        r = d;
        r[i*W +: W] = v;
        return r;
    endfunction

    // Drive one cycle of inputs at the negedge and queue what the next posedge must show.
    task automatic step(input logic rv, input logic [N-1:0] r, input logic [N*W-1:0] d);
        @(negedge clk);
        bus.req      = r;
        bus.req_data = d;
        if (!rv) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            check("async_reset", model_out());
        end else begin
            rst_n = 1'b1;
            model_step(r, d);
        end
        exp_q.push_back(model_out());
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard", e);
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        rst_n        = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        model_reset();

        repeat (3) step(1'b0, 4'b1111, rnd_data());
        step(1'b1, 4'b0100, with_lane(rnd_data(), 2, 16'hBEEF));
        repeat (2)  step(1'b1, 4'b0100, with_lane(rnd_data(), 2, 16'h1234));
        repeat (15) step(1'b1, 4'b0100, rnd_data());
        repeat (6)  step(1'b1, 4'b0000, rnd_data());
        repeat (40) step(1'b1, 4'b0011, rnd_data());
        repeat (16) step(1'b1, 4'b0000, rnd_data());
        repeat (2)  step(1'b1, 4'b1000, with_lane(rnd_data(), 3, 16'hA5A5));
        repeat (20) step(1'b1, 4'b0000, rnd_data());
        repeat (40) step(1'b1, 4'b0010, rnd_data());
        repeat (5)  step(1'b1, 4'b0110, rnd_data());
        repeat (6)  step(1'b1, 4'b1100, rnd_data());
        repeat (2)  step(1'b0, 4'b1100, rnd_data());
        repeat (30) step(1'b1, 4'b1111, rnd_data());

        r = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0)
                repeat (2) step(1'b0, r, rnd_data());
            else
                step(1'b1, r, rnd_data());
        end
        repeat (3) step(1'b1, 4'b0000, rnd_data());

        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
